// File: rtl/regfile_param.sv
// regfile_param - parametrised general-purpose register file for the LCA
// datapath. NREG = 2**ADDR_W registers of WIDTH bits; register NREG-1 is the
// program counter and has its own write port. A per-register busy scoreboard
// marks registers with an outstanding producer.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous, active-high; clears registers and busy bits
//   rd_addr1/rd_addr2    read addresses
//   rd_data1/rd_data2    combinational read data (optional write bypass)
//   rd_busy1/rd_busy2    combinational pending-write flags for the read addresses
//   wr_en/wr_addr/wr_data   general write port; a write also clears busy
//   pc_wr_en/pc_data     dedicated PC write port; wins over a general write to the PC
//   pc_out               stored PC value, never bypassed
//   busy_set/busy_addr   mark a register as pending; ignored for the PC
module regfile_param #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 3,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [WIDTH-1:0]  rd_data1,
  output logic [WIDTH-1:0]  rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              pc_wr_en,
  input  logic [WIDTH-1:0]  pc_data,
  output logic [WIDTH-1:0]  pc_out,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr
);

  localparam int unsigned       NREG    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = '1;

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy;

  // A general write aimed at the PC loses to a simultaneous PC-port write.
  logic gen_wr;
  assign gen_wr = wr_en && !(pc_wr_en && (wr_addr == PC_ADDR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (gen_wr) begin
        regs[wr_addr] <= wr_data;
      end
      if (pc_wr_en) begin
        regs[PC_ADDR] <= pc_data;
      end
      if (wr_en) begin
        busy[wr_addr] <= 1'b0;
      end
      // Issued after the clear so a new producer on the same register wins.
      if (busy_set && (busy_addr != PC_ADDR)) begin
        busy[busy_addr] <= 1'b1;
      end
    end
  end

  // Both read ports share one description; index 0 is port 1, index 1 is port 2.
  logic [ADDR_W-1:0] ra [2];
  logic [WIDTH-1:0]  rd [2];
  logic              rb [2];

  assign ra[0] = rd_addr1;
  assign ra[1] = rd_addr2;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd[p] = regs[ra[p]];
      rb[p] = busy[ra[p]];
      if (BYPASS) begin
        if ((ra[p] == PC_ADDR) && pc_wr_en) begin
          rd[p] = pc_data;
        end else if (wr_en && (wr_addr == ra[p])) begin
          rd[p] = wr_data;
        end
        if (wr_en && (wr_addr == ra[p])) begin
          rb[p] = 1'b0;
        end
      end
      // Bypass paths are combinational from the write ports, so gate them
      // explicitly while reset is held.
      if (reset) begin
        rd[p] = '0;
        rb[p] = 1'b0;
      end
    end
  end

  assign rd_data1 = rd[0];
  assign rd_data2 = rd[1];
  assign rd_busy1 = rb[0];
  assign rd_busy2 = rb[1];
  assign pc_out   = reset ? '0 : regs[PC_ADDR];

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a bypass instance and a non-bypass
// instance share stimulus, a third 32-bit/16-register instance covers the
// wider parametrisation. Expectations go into a scoreboard queue when stimulus
// is applied and are compared when outputs are sampled.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr, busy_addr;
  logic        wr_en, pc_wr_en, busy_set;
  logic [15:0] wr_data, pc_data;

  logic [15:0] a_rd1, a_rd2, a_pc, b_rd1, b_rd2, b_pc;
  logic        a_b1, a_b2, b_b1, b_b2;

  logic [3:0]  c_ra1, c_ra2, c_wa, c_ba;
  logic        c_we, c_pwe, c_bs;
  logic [31:0] c_wd, c_pd, c_rd1, c_rd2, c_pc;
  logic        c_b1, c_b2;

  regfile_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(a_rd1), .rd_data2(a_rd2), .rd_busy1(a_b1), .rd_busy2(a_b2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr_en(pc_wr_en), .pc_data(pc_data), .pc_out(a_pc),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  regfile_param #(.WIDTH(16), .ADDR_W(3), .BYPASS(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .rd_busy1(b_b1), .rd_busy2(b_b2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_wr_en(pc_wr_en), .pc_data(pc_data), .pc_out(b_pc),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  regfile_param #(.WIDTH(32), .ADDR_W(4), .BYPASS(1'b1)) dut_c (
    .clk(clk), .reset(reset),
    .rd_addr1(c_ra1), .rd_addr2(c_ra2),
    .rd_data1(c_rd1), .rd_data2(c_rd2), .rd_busy1(c_b1), .rd_busy2(c_b2),
    .wr_en(c_we), .wr_addr(c_wa), .wr_data(c_wd),
    .pc_wr_en(c_pwe), .pc_data(c_pd), .pc_out(c_pc),
    .busy_set(c_bs), .busy_addr(c_ba)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output selectors for the scoreboard.
  localparam int A_D1 = 0, A_D2 = 1, A_B1 = 2, A_B2 = 3, A_PC = 4;
  localparam int B_D1 = 5, B_D2 = 6, B_B1 = 7, B_B2 = 8, B_PC = 9;
  localparam int C_D1 = 10, C_D2 = 11, C_PC = 12, C_BU1 = 13;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] obs(input int port);
    case (port)
      A_D1:    return {16'h0, a_rd1};
      A_D2:    return {16'h0, a_rd2};
      A_B1:    return {31'h0, a_b1};
      A_B2:    return {31'h0, a_b2};
      A_PC:    return {16'h0, a_pc};
      B_D1:    return {16'h0, b_rd1};
      B_D2:    return {16'h0, b_rd2};
      B_B1:    return {31'h0, b_b1};
      B_B2:    return {31'h0, b_b2};
      B_PC:    return {16'h0, b_pc};
      C_D1:    return c_rd1;
      C_D2:    return c_rd2;
      C_PC:    return c_pc;
      C_BU1:   return {31'h0, c_b1};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Reference model of the 16x8 file (state shared by both instances).
  logic [15:0] m_reg  [8];
  logic        m_busy [8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (wr_en) begin
        m_reg[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (pc_wr_en) m_reg[7] = pc_data;
      if (busy_set && busy_addr != 3'd7) m_busy[busy_addr] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [2:0] a, input bit byp);
    if (reset) return 32'h0;
    if (byp && a == 3'd7 && pc_wr_en) return {16'h0, pc_data};
    if (byp && wr_en && wr_addr == a) return {16'h0, wr_data};
    return {16'h0, m_reg[a]};
  endfunction

  function automatic logic [31:0] exp_busy(input logic [2:0] a, input bit byp);
    if (reset) return 32'h0;
    if (byp && wr_en && wr_addr == a) return 32'h0;
    return {31'h0, m_busy[a]};
  endfunction

  // Push model expectations for every A/B output, then settle and compare.
  task automatic sample();
    push("a_rd1", A_D1, exp_data(rd_addr1, 1'b1));
    push("a_rd2", A_D2, exp_data(rd_addr2, 1'b1));
    push("a_bz1", A_B1, exp_busy(rd_addr1, 1'b1));
    push("a_bz2", A_B2, exp_busy(rd_addr2, 1'b1));
    push("a_pc",  A_PC, reset ? 32'h0 : {16'h0, m_reg[7]});
    push("b_rd1", B_D1, exp_data(rd_addr1, 1'b0));
    push("b_rd2", B_D2, exp_data(rd_addr2, 1'b0));
    push("b_bz1", B_B1, exp_busy(rd_addr1, 1'b0));
    push("b_bz2", B_B2, exp_busy(rd_addr2, 1'b0));
    push("b_pc",  B_PC, reset ? 32'h0 : {16'h0, m_reg[7]});
    #2;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, obs(e.port), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; pc_wr_en = 1'b0; busy_set = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; busy_addr = '0;
    wr_en = 1'b0; pc_wr_en = 1'b0; busy_set = 1'b0;
    wr_data = '0; pc_data = '0;
    c_ra1 = '0; c_ra2 = '0; c_wa = '0; c_ba = '0;
    c_we = 1'b0; c_pwe = 1'b0; c_bs = 1'b0; c_wd = '0; c_pd = '0;
    model_reset();

    // Reset state.
    #1;
    push("rst_a_pc", A_PC, 32'h0);
    push("rst_c_pc", C_PC, 32'h0);
    sample();
    tick();
    tick();
    reset = 1'b0;

    // Basic write then read.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; rd_addr1 = 3'd3;
    sample();
    tick();
    idle();
    push("wr_r3_a", A_D1, 32'h1234);
    push("wr_r3_b", B_D1, 32'h1234);
    sample();

    // Bypass versus stored value.
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1111;
    sample();
    tick();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd_addr2 = 3'd5;
    push("byp_a", A_D2, 32'hBEEF);
    push("nobyp_b", B_D2, 32'h1111);
    sample();
    tick();
    idle();
    push("late_b", B_D2, 32'hBEEF);
    sample();

    // PC port beats a general write to the PC.
    pc_wr_en = 1'b1; pc_data = 16'h0042;
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hFFFF; rd_addr1 = 3'd7;
    push("pc_byp_a", A_D1, 32'h0042);
    sample();
    tick();
    idle();
    push("pc_out_a", A_PC, 32'h0042);
    push("pc_out_b", B_PC, 32'h0042);
    sample();

    // Scoreboard set, clear, set-wins, PC never busy.
    busy_set = 1'b1; busy_addr = 3'd2; rd_addr1 = 3'd2;
    push("set_not_yet", A_B1, 32'h0);
    sample();
    tick();
    idle();
    push("set_seen", A_B1, 32'h1);
    sample();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0202;
    push("clr_byp_a", A_B1, 32'h0);
    push("clr_late_b", B_B1, 32'h1);
    sample();
    tick();
    idle();
    sample();
    busy_set = 1'b1; busy_addr = 3'd4; wr_en = 1'b1; wr_addr = 3'd4;
    wr_data = 16'h4444; rd_addr2 = 3'd4;
    sample();
    tick();
    idle();
    push("set_wins", A_B2, 32'h1);
    sample();
    busy_set = 1'b1; busy_addr = 3'd7; rd_addr1 = 3'd7;
    sample();
    tick();
    idle();
    push("pc_never_busy", A_B1, 32'h0);
    sample();

    // Mixed random traffic.
    for (int i = 0; i < 40; i++) begin
      wr_en    = $urandom_range(0, 1);
      pc_wr_en = ($urandom_range(0, 3) == 0);
      busy_set = $urandom_range(0, 1);
      wr_addr  = 3'($urandom); busy_addr = 3'($urandom);
      rd_addr1 = 3'($urandom); rd_addr2  = 3'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr2 = rd_addr1;
      wr_data  = 16'($urandom); pc_data = 16'($urandom);
      sample();
      tick();
    end

    // Async reset between edges with state present.
    idle();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h3333;
    busy_set = 1'b1; busy_addr = 3'd4;
    pc_wr_en = 1'b1; pc_data = 16'h7777;
    tick();
    idle();
    rd_addr1 = 3'd3; rd_addr2 = 3'd4;
    push("pre_rst_d", A_D1, 32'h3333);
    push("pre_rst_bz", A_B2, 32'h1);
    sample();
    reset = 1'b1;
    model_reset();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h9999;
    push("async_d1", A_D1, 32'h0);
    push("async_bz2", A_B2, 32'h0);
    push("async_pc", A_PC, 32'h0);
    push("async_pc_b", B_PC, 32'h0);
    sample();
    reset = 1'b0;
    wr_data = 16'hABCD;
    sample();
    tick();
    idle();
    push("post_rst_wr", B_D1, 32'hABCD);
    sample();

    // Wider configuration.
    c_pwe = 1'b1; c_pd = 32'hDEADBEEF;
    c_we = 1'b1; c_wa = 4'd9; c_wd = 32'hDEADBEEF;
    c_bs = 1'b1; c_ba = 4'd15;
    @(posedge clk);
    #1;
    c_pwe = 1'b0; c_we = 1'b0; c_bs = 1'b0;
    c_ra1 = 4'd15; c_ra2 = 4'd9;
    push("c_r15", C_D1, 32'hDEADBEEF);
    push("c_r9", C_D2, 32'hDEADBEEF);
    push("c_pc", C_PC, 32'hDEADBEEF);
    push("c_pc_busy", C_BU1, 32'h0);
    sample();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the LCA processor datapath, the successor to the fixed 8×16 file. Width and register count are set by parameters. Two combinational read ports have optional write-to-read bypass. The top register is the program counter, with its own write port. A per-register busy scoreboard lets the decode/hazard unit stall on operands with pending writes.

## Interface
- WIDTH, 16, data width of every register
- ADDR_W, 3, address width; register count NREG = 2^ADDR_W; PC is register NREG-1
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored value only

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  reset is asynchronous and active-high
- rd_addr1, rd_addr2  input  ADDR_W  read addresses
- rd_data1, rd_data2  output  WIDTH  read data, combinational
- rd_busy1, rd_busy2  output  1  addressed register has a pending write, combinational
- wr_en  input  1  general write enable
- wr_addr  input  ADDR_W  general write address
- wr_data  input  WIDTH  general write data
- pc_wr_en  input  1  dedicated PC write enable
- pc_data  input  WIDTH  dedicated PC write data
- pc_out  output  WIDTH  current PC register value, always driven
- busy_set  input  1  mark busy_addr as pending, issued by decode
- busy_addr  input  ADDR_W  register to mark pending

## Operation
- Storage: NREG registers of WIDTH bits and NREG busy bits.
- While reset is high, all registers and busy bits are 0 immediately, without waiting for a clock edge.
- While reset is high, rd_data1/2, pc_out and rd_busy1/2 are 0, and bypass is gated off.
- General write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data.
- PC write: on a rising edge with pc_wr_en=1, reg[NREG-1] <= pc_data.
- Both writes target the PC in the same cycle (pc_wr_en=1, wr_en=1, wr_addr=NREG-1): pc_data wins and wr_data is discarded.
- Scoreboard set: busy_set=1 sets busy[busy_addr] at the edge.
- Scoreboard clear: wr_en=1 clears busy[wr_addr] at the edge. pc_wr_en does not affect busy bits.
- Set and clear hit the same address in one cycle: set wins, and the bit stays 1 (a new producer has been issued).
- busy_set with busy_addr=NREG-1 is ignored; the PC is never busy.
- Read, BYPASS=0: rd_dataN = reg[rd_addrN]; rd_busyN = busy[rd_addrN].
- Read, BYPASS=1, data: if rd_addrN=NREG-1 and pc_wr_en=1, rd_dataN = pc_data; else if wr_en=1 and wr_addr=rd_addrN, rd_dataN = wr_data; else reg[rd_addrN].
- Read, BYPASS=1, busy: rd_busyN = busy[rd_addrN] & ~(wr_en & wr_addr==rd_addrN). A same-cycle busy_set does not show until after the edge.
- pc_out = reg[NREG-1]. It is never bypassed.
- Both read ports are independent and may use the same address.

## Timing
- Write latency: 1 edge. The stored value is visible on rd_data (no bypass) and pc_out from the cycle after the write cycle.
- Bypass latency: 0 cycles, purely combinational from wr_en, wr_addr, wr_data, pc_wr_en and pc_data.
- Scoreboard: a set is visible on rd_busy the cycle after busy_set. A clear is visible in the write cycle when BYPASS=1, and the cycle after when BYPASS=0.
- Reset deasserted mid-operation: first state change at the next rising edge; no partial writes survive reset.
- Max combinational path: address compare plus 2:1 bypass mux plus NREG:1 read mux.

## Test plan
- Reset/basic write-read: assert reset, check all reads and pc_out = 0. Then write 0x1234 to R3 → rd_data1 with rd_addr1=3 shows 0x1234 the next cycle.
- Bypass: wr_en=1, wr_addr=5, wr_data=0xBEEF, rd_addr2=5 in the same cycle → rd_data2=0xBEEF with BYPASS=1. With BYPASS=0, rd_data2 shows the old value and 0xBEEF appears the next cycle.
- PC priority: pc_wr_en=1, pc_data=0x0042, wr_en=1, wr_addr=7, wr_data=0xFFFF (ADDR_W=3) → pc_out=0x0042 after the edge; same-cycle read of R7 returns 0x0042.
- Scoreboard: busy_set on R2 → rd_busy1=1 next cycle. Write R2 → rd_busy1=0 in the write cycle (BYPASS=1). busy_set and write to R4 in one cycle → busy[4]=1 afterwards. busy_set on R7 → rd_busy stays 0.
- Async reset mid-stream: pulse reset between clock edges with busy bits set and registers nonzero → all outputs 0 immediately, before any edge. After release, a write works on the first edge.
- Parametrisation: WIDTH=32, ADDR_W=4 → write 0xDEADBEEF to R15 via pc_wr_en and to R9 via wr_en; verify both values and pc_out.
